// File: rtl/systolic_skew_feeder_if.sv
// Operand feeder bus: tile request handshake, operand SRAM read port and the
// skewed edge outputs into the systolic array.
//   start/base_addr       tile request from the controller (feeder input)
//   rd_en/rd_addr         SRAM read strobe and address (feeder output)
//   rd_data_a/rd_data_b   registered SRAM read data, N lanes packed (feeder input)
//   a_edge/b_edge         skewed operand lanes into the array (feeder output)
//   lane_valid            per-lane data qualifier (feeder output)
//   busy/done/buf_sel     tile status and double-buffer select (feeder output)
// The slave modport is the feeder; the master modport is its surroundings.
interface systolic_skew_feeder_if #(
    parameter int N      = 16,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic                  start;
    logic [ADDR_W-1:0]     base_addr;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [N*DATA_W-1:0]   rd_data_a;
    logic [N*DATA_W-1:0]   rd_data_b;
    logic [N*DATA_W-1:0]   a_edge;
    logic [N*DATA_W-1:0]   b_edge;
    logic [N-1:0]          lane_valid;
    logic                  busy;
    logic                  done;
    logic                  buf_sel;

    modport slave (
        input  start, base_addr, rd_data_a, rd_data_b,
        output rd_en, rd_addr, a_edge, b_edge, lane_valid, busy, done, buf_sel
    );

    modport master (
        output start, base_addr, rd_data_a, rd_data_b,
        input  rd_en, rd_addr, a_edge, b_edge, lane_valid, busy, done, buf_sel
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Operand feeder for an NxN systolic PE array. One accepted start streams K
// SRAM reads (A column vector and B row vector per read), then skews the lanes
// so lane i arrives i cycles after lane 0 and matching A/B elements meet in
// PE(i,j) together. Idle lanes carry zeros with lane_valid low. When the last
// skewed element leaves, done pulses and the double-buffer select flips.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; aborts any tile, clears all outputs
//   bus   systolic_skew_feeder_if.slave (request, SRAM read port, edge outputs)
module systolic_skew_feeder #(
    parameter int N      = 16,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int K      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    systolic_skew_feeder_if.slave bus
);

    localparam int CNT_MAX = (K > N) ? K : N;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_s;
    logic              rd_en_r;
    logic              rd_en_d1_r;   // marks the cycle rd_data is valid
    logic              busy_r;
    logic              done_r;
    logic              buf_sel_r;

    // Next-state, phase counter and read-address sequencing.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        addr_s  = addr_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = READ;
                    cnt_s   = '0;
                    addr_s  = bus.base_addr;
                end else begin
                    addr_s  = '0;
                end
            end
            READ: begin
                if (cnt_r == CNT_W'(K - 1)) begin
                    state_s = FLUSH;
                    cnt_s   = '0;
                    addr_s  = '0;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                    // Natural ADDR_W overflow gives the modulo wrap.
                    addr_s  = addr_r + ADDR_W'(1);
                end
            end
            FLUSH: begin
                if (cnt_r == CNT_W'(N - 1)) begin
                    state_s = DONE;
                    cnt_s   = '0;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
                addr_s  = '0;
            end
        endcase
    end

    // State, counter and address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            addr_r  <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            addr_r  <= addr_s;
        end
    end

    // Control outputs registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en_r    <= 1'b0;
            rd_en_d1_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            buf_sel_r  <= 1'b0;
        end else begin
            rd_en_r    <= (state_s == READ);
            rd_en_d1_r <= rd_en_r;
            busy_r     <= (state_s != IDLE);
            done_r     <= (state_s == DONE);
            // Flip at the end of the DONE cycle so the new buffer is seen after done.
            buf_sel_r  <= (state_r == DONE) ? ~buf_sel_r : buf_sel_r;
        end
    end

    // Lane i owns a stage-0 capture register plus i delay registers. Data and
    // its valid bit move together, and invalid captures load zero, so every
    // idle lane drives zero with no extra masking at the edge.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DATA_W-1:0] a_pipe_r [0:i];
        logic [DATA_W-1:0] b_pipe_r [0:i];
        logic              v_pipe_r [0:i];

        // Capture and shift the skew chain of this lane.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= i; j++) begin
                    a_pipe_r[j] <= '0;
                    b_pipe_r[j] <= '0;
                    v_pipe_r[j] <= 1'b0;
                end
            end else begin
                a_pipe_r[0] <= rd_en_d1_r ? bus.rd_data_a[i*DATA_W +: DATA_W] : '0;
                b_pipe_r[0] <= rd_en_d1_r ? bus.rd_data_b[i*DATA_W +: DATA_W] : '0;
                v_pipe_r[0] <= rd_en_d1_r;
                for (int j = 1; j <= i; j++) begin
                    a_pipe_r[j] <= a_pipe_r[j-1];
                    b_pipe_r[j] <= b_pipe_r[j-1];
                    v_pipe_r[j] <= v_pipe_r[j-1];
                end
            end
        end

        assign bus.a_edge[i*DATA_W +: DATA_W] = a_pipe_r[i];
        assign bus.b_edge[i*DATA_W +: DATA_W] = b_pipe_r[i];
        assign bus.lane_valid[i]              = v_pipe_r[i];
    end

    assign bus.rd_en   = rd_en_r;
    assign bus.rd_addr = addr_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.buf_sel = buf_sel_r;

endmodule
